// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared constants, FSM state type and index helper for the 8-point FFT sequencer
package fft_pkg;

  localparam int FFT_N     = 8;
  localparam int FFT_LOG2N = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_S1    = 3'd2,
    ST_S2    = 3'd3,
    ST_S3    = 3'd4,
    ST_DRAIN = 3'd5
  } fft_ctrl_state_t;

  function automatic logic [2:0] bitrev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

endpackage

// File: rtl/fft_stage_timer.sv
// rtl/fft_stage_timer.sv - loadable down-counter timing one butterfly stage
module fft_stage_timer #(
  parameter int STAGE_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic start,
  output logic expire
);

  logic [3:0] cnt;
  logic       run;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (start) begin
      cnt <= 4'(STAGE_LAT - 1);
      run <= 1'b1;
    end else if (run) begin
      if (cnt == 4'd0) run <= 1'b0;
      else             cnt <= cnt - 4'd1;
    end
  end

  assign expire = run && (cnt == 4'd0);

endmodule

// File: rtl/fft_ctrl.sv
// rtl/fft_ctrl.sv - frame sequencer: bit-reversed load, three timed stages, natural-order drain
// Optional IFFT conjugate/scale outputs are built when FFT_CTRL_IFFT_EN is defined.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int STAGE_LAT = 1,
  parameter int FRAME_CW  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                load_en,
  output logic [2:0]          load_addr,
  output logic [2:0]          stage_en,
  output logic                conj_en,
  output logic [1:0]          scale_shift,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_addr,
  output logic                busy,
  output logic                frame_done,
  output logic [FRAME_CW-1:0] frame_cnt
);

  fft_ctrl_state_t         state, state_nxt;
  logic [FFT_LOG2N-1:0]    smp_cnt, out_cnt;
  logic [FRAME_CW-1:0]     frame_cnt_q;
  logic                    frame_done_q, stage_first;
  logic                    in_hs, out_hs, last_out, timer_start, timer_expire;
  logic                    in_ready_raw, out_valid_raw, live;

  assign live          = !reset;
  assign in_ready_raw  = (state == ST_IDLE) || (state == ST_LOAD);
  assign out_valid_raw = (state == ST_DRAIN);
  // a flush cycle swallows any handshake on either side
  assign in_hs    = in_valid && in_ready_raw && !flush;
  assign out_hs   = out_valid_raw && out_ready && !flush;
  assign last_out = out_hs && (out_cnt == 3'(FFT_N - 1));

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (in_hs) state_nxt = ST_LOAD;
        ST_LOAD:  if (in_hs && smp_cnt == 3'(FFT_N - 1)) state_nxt = ST_S1;
        ST_S1:    if (timer_expire) state_nxt = ST_S2;
        ST_S2:    if (timer_expire) state_nxt = ST_S3;
        ST_S3:    if (timer_expire) state_nxt = ST_DRAIN;
        ST_DRAIN: if (last_out) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  assign timer_start = (state_nxt != state) &&
                       (state_nxt == ST_S1 || state_nxt == ST_S2 || state_nxt == ST_S3);

  fft_stage_timer #(.STAGE_LAT(STAGE_LAT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (flush),
    .start  (timer_start),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      smp_cnt      <= '0;
      out_cnt      <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
      stage_first  <= 1'b0;
    end else begin
      state        <= state_nxt;
      stage_first  <= timer_start;
      frame_done_q <= last_out;
      if (last_out) frame_cnt_q <= frame_cnt_q + FRAME_CW'(1);
      if (flush) begin
        smp_cnt <= '0;
        out_cnt <= '0;
      end else begin
        // both counters wrap to 0 on their eighth step, ready for the next frame
        if (in_hs)  smp_cnt <= smp_cnt + 3'd1;
        if (out_hs) out_cnt <= out_cnt + 3'd1;
      end
    end
  end

  assign in_ready   = live && in_ready_raw;
  assign load_en    = live && in_hs;
  assign load_addr  = live ? bitrev3(smp_cnt) : 3'd0;
  assign stage_en   = live ? {(state == ST_S3) && stage_first,
                              (state == ST_S2) && stage_first,
                              (state == ST_S1) && stage_first} : 3'd0;
  assign out_valid  = live && out_valid_raw;
  assign out_addr   = live ? out_cnt : 3'd0;
  assign busy       = live && (state != ST_IDLE);
  assign frame_done = live && frame_done_q;
  assign frame_cnt  = live ? frame_cnt_q : '0;

`ifdef FFT_CTRL_IFFT_EN
  logic mode_q;

  always_ff @(posedge clk) begin
    if (reset)                             mode_q <= 1'b0;
    else if (state == ST_IDLE && in_hs)    mode_q <= mode;
  end

  assign conj_en     = live && mode_q && (state == ST_LOAD || state == ST_DRAIN);
  assign scale_shift = (live && mode_q && state == ST_DRAIN) ? 2'd3 : 2'd0;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign conj_en     = 1'b0;
  assign scale_shift = 2'd0;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// tb/tb_fft_ctrl.sv - directed self-checking bench for fft_ctrl at STAGE_LAT 1 and 3
module tb_fft_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1, flush = 1'b0, mode = 1'b0, in_valid = 1'b0, out_ready = 1'b0;

  logic       in_ready1, load_en1, conj_en1, out_valid1, busy1, frame_done1;
  logic [2:0] load_addr1, stage_en1, out_addr1;
  logic [1:0] scale_shift1;
  logic [7:0] frame_cnt1;
  logic       in_ready3, load_en3, conj_en3, out_valid3, busy3, frame_done3;
  logic [2:0] load_addr3, stage_en3, out_addr3;
  logic [1:0] scale_shift3;
  logic [7:0] frame_cnt3;

  int n_checks = 0;
  int n_errors = 0;
  int br_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

`ifdef FFT_CTRL_IFFT_EN
  localparam int IFFT_ON = 1;
`else
  localparam int IFFT_ON = 0;
`endif

  always #5 clk = ~clk;

  fft_ctrl #(.STAGE_LAT(1), .FRAME_CW(8)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready1), .load_en(load_en1), .load_addr(load_addr1), .stage_en(stage_en1),
    .conj_en(conj_en1), .scale_shift(scale_shift1), .out_valid(out_valid1),
    .out_ready(out_ready), .out_addr(out_addr1), .busy(busy1), .frame_done(frame_done1),
    .frame_cnt(frame_cnt1)
  );

  fft_ctrl #(.STAGE_LAT(3), .FRAME_CW(8)) u_dut3 (
    .clk(clk), .reset(reset), .flush(flush), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready3), .load_en(load_en3), .load_addr(load_addr3), .stage_en(stage_en3),
    .conj_en(conj_en3), .scale_shift(scale_shift3), .out_valid(out_valid3),
    .out_ready(out_ready), .out_addr(out_addr3), .busy(busy3), .frame_done(frame_done3),
    .frame_cnt(frame_cnt3)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // inputs change on the falling edge; outputs are sampled 1ns later
  task automatic step(input logic iv, input logic orr, input logic fl = 1'b0,
                      input logic rs = 1'b0, input logic md = 1'b0);
    @(negedge clk);
    in_valid = iv; out_ready = orr; flush = fl; reset = rs; mode = md;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state and a plain STAGE_LAT=1 frame
    step(1, 1, 0, 1);
    check("rst_in_ready", int'(in_ready1), 0);
    check("rst_load_en", int'(load_en1), 0);
    check("rst_busy", int'(busy1), 0);
    check("rst_out_valid", int'(out_valid1), 0);
    check("rst_frame_cnt", int'(frame_cnt1), 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 1);
      check("a_in_ready", int'(in_ready1), 1);
      check("a_load_en", int'(load_en1), 1);
      check("a_load_addr", int'(load_addr1), br_tab[i]);
    end
    step(0, 1); check("a_stage1", int'(stage_en1), 1);
    step(0, 1); check("a_stage2", int'(stage_en1), 2);
    step(0, 1); check("a_stage3", int'(stage_en1), 4);
    for (int j = 0; j < 8; j++) begin
      step(0, 1);
      check("a_out_valid", int'(out_valid1), 1);
      check("a_out_addr", int'(out_addr1), j);
    end
    step(0, 1);
    check("a_frame_done", int'(frame_done1), 1);
    check("a_frame_cnt", int'(frame_cnt1), 1);
    check("a_in_ready_after", int'(in_ready1), 1);
    check("a_busy_after", int'(busy1), 0);
    step(0, 1);
    check("a_done_pulse", int'(frame_done1), 0);

    // STAGE_LAT=3 with gapped input, then a stalled drain
    step(0, 1, 0, 1);
    for (int i = 0; i < 15; i++) begin
      step(i % 2 == 0, 1);
      check("b_no_stage", int'(stage_en3), 0);
      if (i % 2 == 0) check("b_load_addr", int'(load_addr3), br_tab[i / 2]);
    end
    for (int k = 1; k <= 9; k++) begin
      step(0, 1);
      check("b_stage_seq", int'(stage_en3), (k == 1) ? 1 : (k == 4) ? 2 : (k == 7) ? 4 : 0);
      check("b_no_out", int'(out_valid3), 0);
    end
    for (int j = 0; j < 4; j++) begin
      step(0, 1);
      check("c_out_valid", int'(out_valid3), 1);
      check("c_out_addr", int'(out_addr3), j);
    end
    for (int s = 0; s < 5; s++) begin
      step(0, 0);
      check("c_stall_valid", int'(out_valid3), 1);
      check("c_stall_addr", int'(out_addr3), 4);
    end
    for (int j = 4; j < 8; j++) begin
      step(0, 1);
      check("c_out_addr2", int'(out_addr3), j);
    end
    step(0, 1);
    check("c_frame_done", int'(frame_done3), 1);
    check("c_frame_cnt", int'(frame_cnt3), 1);

    // reset mid-LOAD after five samples
    for (int i = 0; i < 5; i++) begin
      step(1, 1);
      check("e_load_addr", int'(load_addr3), br_tab[i]);
    end
    step(1, 1, 0, 1);
    check("e_rst_in_ready", int'(in_ready3), 0);
    check("e_rst_load_en", int'(load_en3), 0);
    check("e_rst_load_addr", int'(load_addr3), 0);
    check("e_rst_busy", int'(busy3), 0);
    check("e_rst_frame_cnt", int'(frame_cnt3), 0);
    check("e_rst_stage", int'(stage_en3), 0);
    check("e_rst_frame_done", int'(frame_done3), 0);
    step(0, 1, 0, 1);
    for (int i = 0; i < 7; i++) begin
      step(1, 1);
      check("e_reload_addr", int'(load_addr3), br_tab[i]);
    end
    step(0, 1);
    check("e_wait_busy", int'(busy3), 1);
    check("e_wait_stage", int'(stage_en3), 0);
    check("e_wait_ready", int'(in_ready3), 1);
    step(1, 1); check("e_last_addr", int'(load_addr3), 7);
    step(0, 1); check("e_stage1", int'(stage_en3), 1);
    step(0, 1);
    step(0, 1);

    // flush in S2 with in_valid high, then flush during LOAD
    step(1, 1, 1);
    check("d_flush_stage", int'(stage_en3), 2);
    check("d_flush_load_en", int'(load_en3), 0);
    step(0, 1);
    check("d_idle_busy", int'(busy3), 0);
    check("d_idle_ready", int'(in_ready3), 1);
    check("d_frame_cnt", int'(frame_cnt3), 0);
    check("d_no_done", int'(frame_done3), 0);
    step(1, 1); check("d_next_addr0", int'(load_addr3), 0);
    step(1, 1); check("d_next_addr1", int'(load_addr3), 4);
    step(1, 1, 1);
    check("d_ld_flush_load_en", int'(load_en3), 0);
    step(1, 1);
    check("d_after_flush_addr", int'(load_addr3), 0);
    check("d_after_flush_en", int'(load_en3), 1);

    // IFFT mode latched on the first sample only
    step(0, 1, 0, 1);
    step(1, 1, 0, 0, 1);
    check("f_idle_conj", int'(conj_en1), 0);
    for (int i = 1; i < 8; i++) begin
      step(1, 1);
      check("f_load_conj", int'(conj_en1), IFFT_ON);
      check("f_load_shift", int'(scale_shift1), 0);
    end
    step(0, 1); check("f_s1_conj", int'(conj_en1), 0);
    step(0, 1);
    step(0, 1);
    for (int j = 0; j < 8; j++) begin
      step(0, 1);
      check("f_drain_conj", int'(conj_en1), IFFT_ON);
      check("f_drain_shift", int'(scale_shift1), IFFT_ON * 3);
      check("f_drain_addr", int'(out_addr1), j);
    end
    step(0, 1);
    check("f_frame_done", int'(frame_done1), 1);
    check("f_frame_cnt", int'(frame_cnt1), 1);
    check("f_idle_conj2", int'(conj_en1), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
